// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, read-only instruction cache for the fetch stage.
// A hit is answered combinationally from pcF. A miss stalls fetch and
// refills the whole line from backing memory over a req/valid burst.
module instr_cache #(
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pcF,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] instrF,
    output logic                  stallF,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(SETS);
    localparam int LO_W  = OFF_W + 2;
    localparam int TAG_W = DATA_WIDTH - LO_W - IDX_W;

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
    localparam logic [OFF_W-1:0]      LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_t;

    // Control state
    state_t                  state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic [DATA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [OFF_W-1:0]        cnt_q, cnt_d;
    logic [SETS-1:0]         valid_q, valid_d;
    logic                    flush_pend_q, flush_pend_d;

    // Line storage (no reset needed: valid bits gate every use)
    logic [TAG_W-1:0]        tag_q  [SETS];
    logic [DATA_WIDTH-1:0]   data_q [SETS][WORDS_PER_LINE];

    // Storage write strobes produced by the controller
    logic                    data_we;
    logic                    tag_we;
    logic [SETS-1:0]         line_sel;

    // Address fields of the current fetch and of the line being refilled
    logic [OFF_W-1:0]        pc_word;
    logic [IDX_W-1:0]        pc_idx;
    logic [TAG_W-1:0]        pc_tag;
    logic [IDX_W-1:0]        refill_idx;
    logic [TAG_W-1:0]        refill_tag;
    logic                    hit;

    // Byte offset within a word never selects anything
    logic                    unused_pc_bits;
    assign unused_pc_bits = ^pcF[1:0];

    assign pc_word    = pcF[2 +: OFF_W];
    assign pc_idx     = pcF[LO_W +: IDX_W];
    assign pc_tag     = pcF[DATA_WIDTH-1 -: TAG_W];
    assign refill_idx = mem_addr_q[LO_W +: IDX_W];
    assign refill_tag = mem_addr_q[DATA_WIDTH-1 -: TAG_W];

    // One-hot decode of the line under refill
    for (genvar gi = 0; gi < SETS; gi++) begin : g_line_sel
        assign line_sel[gi] = (refill_idx == IDX_W'(gi));
    end

    // Lookup: only IDLE may hit; anything else stalls and returns a NOP
    always_comb begin
        hit    = (state_q == ST_IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
        stallF = ~hit;
        instrF = hit ? data_q[pc_idx][pc_word] : NOP_INSTR;
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    // Next-state logic: start refill on a miss, absorb beats, handle flush
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end
                if (!hit) begin
                    state_d    = ST_REFILL;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pc_tag, pc_idx, {LO_W{1'b0}}};
                    cnt_d      = '0;
                end
            end

            ST_REFILL: begin
                // A flush during the burst must also keep the incoming line invalid
                if (flush) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b1;
                end
                if (mem_req_q && mem_valid) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + OFF_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        tag_we       = 1'b1;
                        state_d      = ST_IDLE;
                        mem_req_d    = 1'b0;
                        cnt_d        = '0;
                        flush_pend_d = 1'b0;
                        if (!flush && !flush_pend_q) begin
                            valid_d[refill_idx] = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            cnt_q        <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Line storage writes: one word per accepted beat, tag on the last beat
    always_ff @(posedge clk) begin
        for (int s = 0; s < SETS; s++) begin
            if (data_we && line_sel[s]) begin
                data_q[s][cnt_q] <= mem_rdata;
            end
            if (tag_we && line_sel[s]) begin
                tag_q[s] <= refill_tag;
            end
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: randomized self-checking bench for instr_cache. The reference
// is a backing-memory array plus a queue of cached line addresses.
module tb_instr_cache;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        flush;
    logic [31:0] instrF;
    logic        stallF;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] backing [0:1023];   // instruction memory, 4 KB
    logic [31:0] ref_lines[$];       // line addresses currently cached

    instr_cache dut (
        .clk       (clk),
        .rst       (rst),
        .pcF       (pcF),
        .flush     (flush),
        .instrF    (instrF),
        .stallF    (stallF),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic bit model_has(input logic [31:0] line);
        foreach (ref_lines[i]) begin
            if (ref_lines[i] == line) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Direct mapped: a new line displaces whatever shares its set number
    function automatic void model_insert(input logic [31:0] line);
        logic [31:0] keep[$];
        foreach (ref_lines[i]) begin
            if (((ref_lines[i] >> 4) % 16) != ((line >> 4) % 16)) keep.push_back(ref_lines[i]);
        end
        keep.push_back(line);
        ref_lines = keep;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Fetch pc until it hits, serving any refill with random gaps; flush on beat fbeat
    task automatic fetch(input logic [31:0] pc, input int gmin, input int gmax,
                         input int fbeat, output int nref);
        logic [31:0] line;
        int          base;
        int          gaps;
        bit          flushed;
        bit          done;
        line = {pc[31:4], 4'b0000};
        base = int'(line[11:2]);
        nref = 0;
        done = 1'b0;
        for (int it = 0; it < 4 && !done; it++) begin
            pcF       = pc;
            flush     = 1'b0;
            mem_valid = 1'b1;              // stray beat while no burst is open
            mem_rdata = $urandom;
            @(negedge clk);
            if (model_has(line)) begin
                n_checks++;
                if (stallF !== 1'b0 || instrF !== backing[pc[11:2]] || mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hit pc=%h: got stallF=%b instrF=%h mem_req=%b, want stallF=0 instrF=%h mem_req=0",
                             pc, stallF, instrF, mem_req, backing[pc[11:2]]);
                end
                next_cycle();
                mem_valid = 1'b0;
                done = 1'b1;
            end else begin
                n_checks++;
                if (stallF !== 1'b1 || instrF !== NOP || mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL miss_detect pc=%h: got stallF=%b instrF=%h mem_req=%b, want stallF=1 instrF=%h mem_req=0",
                             pc, stallF, instrF, mem_req, NOP);
                end
                next_cycle();
                nref++;
                flushed = 1'b0;
                for (int beat = 0; beat < 4; beat++) begin
                    gaps = int'($urandom_range(gmax, gmin));
                    for (int g = 0; g <= gaps; g++) begin
                        pcF       = $urandom_range(0, 32'hFFF);
                        mem_valid = (g == gaps);
                        mem_rdata = (g == gaps) ? backing[base + beat] : $urandom;
                        flush     = (g == gaps) && (beat == fbeat);
                        if (flush) flushed = 1'b1;
                        @(negedge clk);
                        n_checks++;
                        if (mem_req !== 1'b1 || mem_addr !== line || stallF !== 1'b1 || instrF !== NOP) begin
                            n_fail++;
                            $display("FAIL refill beat=%0d: got mem_req=%b mem_addr=%h stallF=%b instrF=%h, want 1 %h 1 %h",
                                     beat, mem_req, mem_addr, stallF, instrF, line, NOP);
                        end
                        next_cycle();
                    end
                end
                flush     = 1'b0;
                mem_valid = 1'b0;
                if (flushed) ref_lines.delete();
                else model_insert(line);
                fbeat = -1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL fetch_bound pc=%h: got no hit after 4 lookups, want a hit", pc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            pcF = $urandom;
            @(negedge clk);
            n_checks++;
            if (stallF !== 1'b1 || instrF !== NOP || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_state: got stallF=%b instrF=%h mem_req=%b mem_addr=%h, want 1 %h 0 0",
                         stallF, instrF, mem_req, mem_addr, NOP);
            end
        end
        next_cycle();
        rst = 1'b0;
        ref_lines.delete();
    endtask

    task automatic test_cold_miss();
        int n;
        fetch(32'h0, 0, 0, -1, n);
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL cold_miss_refills: got %0d, want 1", n);
        end
        for (int a = 4; a <= 12; a += 4) begin
            fetch(32'(a), 0, 0, -1, n);
            n_checks++;
            if (n !== 0) begin
                n_fail++;
                $display("FAIL cold_line_hits pc=%h: got %0d refills, want 0", a, n);
            end
        end
    endtask

    task automatic test_gapped_burst();
        int n;
        fetch(32'h40, 1, 1, -1, n);
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL gapped_refills: got %0d, want 1", n);
        end
    endtask

    task automatic test_conflict();
        int n;
        fetch(32'h0, 0, 0, -1, n);
        fetch(32'h100, 0, 2, -1, n);
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL conflict_fill: got %0d refills, want 1", n);
        end
        fetch(32'h4, 0, 0, -1, n);
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL conflict_evict: got %0d refills, want 1", n);
        end
    endtask

    task automatic test_flush_idle();
        int n;
        fetch(32'h8, 0, 0, -1, n);
        pcF   = 32'h8;
        flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stallF !== 1'b0 || instrF !== backing[2]) begin
            n_fail++;
            $display("FAIL flush_cycle_hit: got stallF=%b instrF=%h, want 0 %h", stallF, instrF, backing[2]);
        end
        next_cycle();
        flush = 1'b0;
        ref_lines.delete();
        fetch(32'h8, 0, 0, -1, n);
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL flush_idle_refills: got %0d, want 1", n);
        end
    endtask

    task automatic test_flush_mid_refill();
        int n;
        fetch(32'h84, 0, 2, 2, n);
        n_checks++;
        if (n !== 2) begin
            n_fail++;
            $display("FAIL flush_mid_refills: got %0d, want 2", n);
        end
        fetch(32'hC8, 0, 1, 3, n);
        n_checks++;
        if (n !== 2) begin
            n_fail++;
            $display("FAIL flush_last_beat_refills: got %0d, want 2", n);
        end
    endtask

    task automatic test_reset_mid_refill();
        int n;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        ref_lines.delete();
        pcF       = 32'h0;
        mem_valid = 1'b0;
        next_cycle();
        for (int b = 0; b < 3; b++) begin
            mem_valid = 1'b1;
            mem_rdata = backing[b];
            @(negedge clk);
            n_checks++;
            if (mem_req !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_mid_beat%0d: got mem_req=%b, want 1", b, mem_req);
            end
            next_cycle();
        end
        rst       = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        next_cycle();
        rst       = 1'b0;
        mem_valid = 1'b0;
        ref_lines.delete();
        fetch(32'h0, 0, 1, -1, n);
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL rst_mid_refills: got %0d, want 1", n);
        end
    endtask

    task automatic test_random();
        int          n;
        int          fb;
        logic [31:0] pc;
        for (int i = 0; i < 80; i++) begin
            pc = $urandom_range(0, 32'h3FF);
            fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            fetch(pc, 0, int'($urandom_range(0, 2)), fb, n);
            if ($urandom_range(0, 9) == 0) begin
                pcF   = pc;
                flush = 1'b1;
                @(negedge clk);
                n_checks++;
                if (stallF !== !model_has({pc[31:4], 4'b0000})) begin
                    n_fail++;
                    $display("FAIL random_flush_lookup pc=%h: got stallF=%b, want %b",
                             pc, stallF, !model_has({pc[31:4], 4'b0000}));
                end
                next_cycle();
                flush = 1'b0;
                ref_lines.delete();
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        pcF       = 32'h0;
        flush     = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) backing[i] = $urandom;
        backing[0] = 32'h11;
        backing[1] = 32'h22;
        backing[2] = 32'h33;
        backing[3] = 32'h44;

        test_reset();
        test_cold_miss();
        test_gapped_burst();
        test_conflict();
        test_flush_idle();
        test_flush_mid_refill();
        test_reset_mid_refill();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache answering the fetch stage's instruction reads. It serves the word at `pcF` in the same cycle on a hit, and raises `stallF` on a miss. It then refills the line from a backing instruction memory over a request/valid burst interface. It replaces the flat instruction ROM between the PC logic and instruction memory. It is the responder for every fetch address the PC produces.

## Interface
- `DATA_WIDTH`, 32, instruction/address width
- `SETS`, 16, number of lines (power of two)
- `WORDS_PER_LINE`, 4, 32-bit words per line (power of two, ≥2)

- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `pcF`  in  DATA_WIDTH  fetch byte address; bits [1:0] ignored
- `flush`  in  1  invalidate all lines (fence.i); one-cycle pulse
- `instrF`  out  DATA_WIDTH  instruction for `pcF`; 0x00000013 (NOP) whenever `stallF`=1
- `stallF`  out  1  fetch must hold PC; combinational
- `mem_req`  out  1  refill burst active (registered)
- `mem_addr`  out  DATA_WIDTH  line-aligned refill address (registered)
- `mem_valid`  in  1  `mem_rdata` beat valid this cycle
- `mem_rdata`  in  DATA_WIDTH  refill beat, words in ascending address order

## Operation
- Address split: `[1:0]` byte, then log2(WORDS_PER_LINE) word offset, then log2(SETS) index, remainder tag. With defaults: word = `[3:2]`, index = `[7:4]`, tag = `[31:8]`.
- Storage: per-line valid bit, tag register, and WORDS_PER_LINE data words, held in flops. Reads are asynchronous.
- Hit: `state`=IDLE and `valid[idx]` and `tag[idx]==pcF.tag`. Then `instrF`=data[idx][word] and `stallF`=0.
- FSM states: IDLE and REFILL.
  - IDLE → REFILL on the edge where a miss is present.
    - Latch `mem_addr = {pcF.tag, pcF.idx, 0...}`.
    - Set `mem_req`=1.
    - Clear the beat counter.
  - REFILL: each cycle with `mem_valid`=1 writes `mem_rdata` into word[counter] of the latched index, then increments the counter.
  - On the beat where counter == WORDS_PER_LINE-1:
    - Write the tag and set the valid bit.
    - Clear `mem_req` at that edge.
    - Return to IDLE.
- `stallF`=1 during all of REFILL, regardless of `pcF`.
- `mem_valid` is ignored while `mem_req`=0.
- Changes to `pcF` during REFILL do not alter the burst. After returning to IDLE, the lookup uses the current `pcF`; a different missing line starts a new refill.
- `flush`:
  - In IDLE: clears every valid bit at the edge.
  - In REFILL: clears every valid bit and sets a pending flag. The in-flight line completes with valid=0, and the flag is then cleared.
- Refill overwrites the indexed line unconditionally (no replacement choice).

## Timing
- Reset values:
  - state IDLE, `mem_req`=0, `mem_addr`=0, counter 0, all valid bits 0, flush pending 0.
  - Consequently `stallF`=1 and `instrF`=NOP for any `pcF` after reset.
- Hit latency 0: combinational from `pcF`.
- Miss, when the miss is seen in cycle 0:
  - `mem_req` rises in cycle 1.
  - The backing memory may assert `mem_valid` from cycle 1 onward, with arbitrary gaps.
  - If the last beat arrives in cycle k, then in cycle k+1 `mem_req`=0, the state is IDLE and the same `pcF` hits.
  - Minimum miss penalty is WORDS_PER_LINE+1 stall cycles (5 with defaults).
- `mem_addr` is stable throughout `mem_req`=1.
- `rst` mid-refill: the next edge forces IDLE with `mem_req`=0 and all lines invalid. Later `mem_valid` pulses are ignored.
- `rst` has priority over `flush`, and `flush` has priority over the refill valid-set.

## Test plan
- Cold miss:
  - Stimulus: reset, `pcF`=0x0. Memory returns 0x11, 0x22, 0x33, 0x44 on consecutive cycles starting cycle 1.
  - Required: `stallF`=1 in cycles 0–4; `mem_req`=1 with `mem_addr`=0x0 in cycles 1–4; cycle 5 `stallF`=0, `instrF`=0x11.
  - Then `pcF`=0x4, 0x8, 0xC → 0x22, 0x33, 0x44, with no `mem_req`.
- Gapped burst:
  - Stimulus: `pcF`=0x40, `mem_valid` on alternate cycles.
  - Required: `mem_req` held high and `mem_addr`=0x40 for all 8 cycles; correct words; stall ends the cycle after the 4th beat.
- Conflict:
  - Stimulus: fill line 0x000, then `pcF`=0x100 (same index 0, different tag).
  - Required: miss and refill at `mem_addr`=0x100; afterwards `pcF`=0x000 misses again.
- Flush idle:
  - Stimulus: line 0x0 valid, `flush` pulsed.
  - Required: next cycle `pcF`=0x0 gives `stallF`=1 and a new refill.
- Flush mid-refill:
  - Stimulus: `flush` pulsed at beat 2.
  - Required: the burst completes (4 beats), then the same `pcF` misses and a second burst starts.
- Reset mid-refill:
  - Stimulus: `rst` asserted after beat 2.
  - Required: next cycle `mem_req`=0; stray `mem_valid`/data is ignored; `pcF`=0x0 still misses.
